twos_comp_pipe: RTL
===================

Name: twos_comp_pipe

Overview:
- Parametrised, pipelined successor to the combinational 32-bit two's-complement unit used in the signed Vedic multiplier.
- Sits on the operand path ahead of the unsigned Vedic core and on the product path after it.
- Converts sign-magnitude ↔ two's complement under a per-transaction mode.
- Splits the +1 carry chain across two register stages and uses a valid/ready handshake with full back-pressure.

Parameters:
- WIDTH, 32, data width in bits; even, ≥4.
- LO_W, WIDTH/2, bits of the increment chain resolved in stage 1; the remaining WIDTH-LO_W bits are resolved in stage 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream transaction valid
- in_ready  output  1  unit accepts the transaction this cycle
- in_data  input  WIDTH  operand
- in_mode  input  2  00 pass, 01 negate, 10 abs, 11 conditional negate by in_sign
- in_sign  input  1  negate-enable for mode 11 (e.g. sign_a XOR sign_b)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  result
- out_ovf  output  1  negation of most-negative value (1000…0) occurred

Behaviour:
- Reset (async assert, sync release is the integrator's job): both stage valids 0; out_valid 0; out_data 0; out_ovf 0; in_ready 1.
- Negate decision (neg) is resolved at stage 1 input:
  - mode 00: neg=0
  - mode 01: neg=1
  - mode 10: neg=in_data[WIDTH-1]
  - mode 11: neg=in_sign
- Stage 1, on accept:
  - x = neg ? ~in_data : in_data
  - store low sum x[LO_W-1:0] + neg (LO_W bits), the carry-out c1, the raw x high part, neg, and ovf1 = neg AND (in_data == 1 followed by WIDTH-1 zeros).
- Stage 2, on advance:
  - high part = x_hi + c1 (modulo)
  - out_data = {high, low}
  - out_ovf = ovf1 (result wraps to 1000…0 unless SAT_EN is defined)
- Arithmetic: all modulo 2^WIDTH; no width growth.
- Handshake: transfer on valid AND ready on each side.
  - Stage 2 loads when empty or out_ready=1.
  - Stage 1 loads when empty or stage 2 loads.
  - in_ready = !v1 | !v2 | out_ready (combinational, no bubble).
- Latency: 2 cycles from accept to out_valid. Throughput: 1 per cycle when out_ready is held 1.
- Stall: out_ready=0 with both stages full → in_ready=0. out_data, out_ovf and out_valid are held stable until the transfer.
- Simultaneous: the output transfer and the input accept in the same cycle are both honoured; no transaction is dropped or duplicated.
- out_valid never deasserts without a transfer.
- Reset mid-operation: in-flight transactions are discarded; outputs return to reset values immediately.

Optional Feature:
- Macro: TWOS_COMP_PIPE_SAT_EN.
- Defined: when ovf1 is set, stage 2 outputs 0111…1 (max positive); out_ovf still asserted.
- Undefined: result wraps to 1000…0; out_ovf asserted. No other behaviour differs.

Decomposition:
- Package sign_arith_pkg:
  - mode constants MODE_PASS=2'b00, MODE_NEG=2'b01, MODE_ABS=2'b10, MODE_CNEG=2'b11
  - function for the most-negative constant of a width
- One sub-module, inc_slice: a W-bit conditional increment that returns sum and carry-out. It is instantiated once per stage (LO_W and WIDTH-LO_W).

Test Plan:
- WIDTH=32, mode 01, in_data=0x0000_0005, out_ready=1 → 2 cycles later out_data=0xFFFF_FFFB, out_ovf=0.
- mode 10, in_data=0xFFFF_0000 (carry crosses the half boundary) → 0x0001_0000. Same mode, in_data=0x0000_1234 → 0x0000_1234.
- mode 01, in_data=0x8000_0000 → out_ovf=1, out_data=0x8000_0000; with TWOS_COMP_PIPE_SAT_EN, out_data=0x7FFF_FFFF.
- Back-to-back stream of 8 mode-11 operands with alternating in_sign, out_ready held 0 for 3 cycles mid-stream:
  - in_ready drops once both stages are full
  - results arrive in order, none lost or duplicated
  - out_data stable during the stall
- Assert rst_n low for 1 cycle with 2 transactions in flight → out_valid=0 and out_data=0 at once; first post-reset transaction is correct.
- mode 00, in_data=0x0000_0000 and mode 01, in_data=0x0000_0000 → both give out_data=0x0000_0000, out_ovf=0.

Source files
------------

// File: rtl/sign_arith_pkg.sv
// Shared constants and helpers for the sign-handling datapath.
// Holds the transaction mode encodings and a generator for the
// most-negative two's-complement value of a given width.
package sign_arith_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_CNEG = 2'b11;

  // Upper bound on the width most_neg can describe; callers truncate.
  localparam int MAX_W = 256;

  // Returns 1 followed by (w-1) zeros, right-aligned in MAX_W bits.
  function automatic logic [MAX_W-1:0] most_neg(input int w);
    logic [MAX_W-1:0] r;
    r        = '0;
    r[w-1]   = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/inc_slice.sv
// Conditional W-bit incrementer: sum = a + inc, with carry-out.
// One instance resolves each half of the +1 chain.
module inc_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic         inc,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {{W{1'b0}}, inc};

endmodule

// File: rtl/twos_comp_pipe.sv
// Two-stage pipelined sign-magnitude <-> two's-complement converter.
// Stage 1 inverts the operand when negating and resolves the low half of
// the +1 chain; stage 2 finishes the high half with the stored carry.
// Full valid/ready back-pressure, no bubble when both stages are full.
// Optional macro TWOS_COMP_PIPE_SAT_EN: negating the most-negative value
// yields max positive instead of wrapping (out_ovf is flagged either way).
module twos_comp_pipe
  import sign_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int              HI_W     = WIDTH - LO_W;
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

`ifdef TWOS_COMP_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = ~MOST_NEG;

  // Clamp the wrapped negation of the most-negative value to max positive.
  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] raw,
                                                  input logic             ovf);
    return ovf ? MAX_POS : raw;
  endfunction
`endif

  logic             neg;
  logic [WIDTH-1:0] x;
  logic [LO_W-1:0]  lo_sum;
  logic             lo_carry;
  logic             ovf_in;
  logic             accept;
  logic             load_p1;
  logic             load_p2;

  logic             vld_p1;
  logic [LO_W-1:0]  lo_sum_p1;
  logic             c1_p1;
  logic [HI_W-1:0]  x_hi_p1;
  logic             ovf_p1;

  logic [HI_W-1:0]  hi_sum;
  logic             hi_carry_unused;
  logic [WIDTH-1:0] result;

  logic             vld_p2;
  logic [WIDTH-1:0] data_p2;
  logic             ovf_p2;

  // Negate decision from the transaction mode.
  always_comb begin
    neg = 1'b0;
    case (in_mode)
      MODE_PASS: neg = 1'b0;
      MODE_NEG:  neg = 1'b1;
      MODE_ABS:  neg = in_data[WIDTH-1];
      MODE_CNEG: neg = in_sign;
      default:   neg = 1'b0;
    endcase
  end

  assign x      = neg ? ~in_data : in_data;
  assign ovf_in = neg & (in_data == MOST_NEG);

  inc_slice #(.W(LO_W)) u_inc_lo (
    .a    (x[LO_W-1:0]),
    .inc  (neg),
    .sum  (lo_sum),
    .cout (lo_carry)
  );

  // Handshake: stage 2 drains when empty or downstream takes it; stage 1
  // refills whenever stage 2 moves or it is empty itself.
  assign load_p2  = !vld_p2 | out_ready;
  assign load_p1  = !vld_p1 | load_p2;
  assign in_ready = !vld_p1 | !vld_p2 | out_ready;
  assign accept   = in_valid & in_ready;

  // Stage valids; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (load_p1) vld_p1 <= in_valid;
      if (load_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1 -> stage 2 boundary: low half done, high half pending ----
  // Capture the partially incremented operand on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_sum_p1 <= lo_sum;
      c1_p1     <= lo_carry;
      x_hi_p1   <= x[WIDTH-1:LO_W];
      ovf_p1    <= ovf_in;
    end
  end

  inc_slice #(.W(HI_W)) u_inc_hi (
    .a    (x_hi_p1),
    .inc  (c1_p1),
    .sum  (hi_sum),
    .cout (hi_carry_unused)
  );

`ifdef TWOS_COMP_PIPE_SAT_EN
  assign result = sat_result({hi_sum, lo_sum_p1}, ovf_p1);
`else
  assign result = {hi_sum, lo_sum_p1};
`endif

  // ---- stage 2 -> output boundary: held stable while stalled ----
  // Output register; cleared on reset so the port reads zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p2 <= '0;
      ovf_p2  <= 1'b0;
    end else if (load_p2 && vld_p1) begin
      data_p2 <= result;
      ovf_p2  <= ovf_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_ovf   = ovf_p2;

endmodule
